// File: rtl/stopwatch_core.sv
// -----------------------------------------------------------------------------
// stopwatch_core
//
// BCD stopwatch (MM:SS.t) counting rising edges of the slow divider output.
// Each synchronized rising edge of dividedClock produces a one-cycle tick.
// While running, each tick advances the count by one tenth. A start/stop/clear
// state machine controls the counter. A lap hold freezes the displayed value
// while the live count keeps running.
//
// Parameters:
//   SYNC_STAGES   synchronizer depth on dividedClock (2..4)
//   WRAP_MINUTES  minute value at which the count wraps to 00:00.0 (1..99)
//
// Ports:
//   sysClk, sysRstN        clock, asynchronous active-low reset
//   dividedClock           asynchronous slow square wave, one count per rise
//   startStopPulse         1-cycle request: IDLE->RUN, RUN<->PAUSE
//   clearPulse             1-cycle request: zero count (IDLE/PAUSE only)
//   lapPulse               1-cycle request: toggle lap hold (RUN/PAUSE only)
//   tenths..minTens        registered BCD display digits
//   running                high while in RUN
//   lapActive              high while the display is frozen
//   overflowPulse          1-cycle pulse when the live count wraps to zero
// -----------------------------------------------------------------------------
module stopwatch_core #(
  parameter int SYNC_STAGES  = 2,
  parameter int WRAP_MINUTES = 60
) (
  input  logic       sysClk,
  input  logic       sysRstN,
  input  logic       dividedClock,
  input  logic       startStopPulse,
  input  logic       clearPulse,
  input  logic       lapPulse,
  output logic [3:0] tenths,
  output logic [3:0] secOnes,
  output logic [3:0] secTens,
  output logic [3:0] minOnes,
  output logic [3:0] minTens,
  output logic       running,
  output logic       lapActive,
  output logic       overflowPulse
);

  localparam int         LAST      = SYNC_STAGES - 1;
  localparam logic [3:0] WRAP_TENS = 4'(WRAP_MINUTES / 10);
  localparam logic [3:0] WRAP_ONES = 4'(WRAP_MINUTES % 10);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

  typedef struct packed {
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic [3:0] tenths;
  } count_t;

  // ---------------------------------------------------------------------------
  // Tick generation
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [SYNC_STAGES-1:0] valid_q, valid_d;
  logic                   edge_q, edge_d;
  logic                   tick;

  // valid_q marks which sync stages hold real samples since reset release.
  // Until the last stage is valid, the edge register is forced to 1, so a
  // dividedClock that is already high at release is not seen as a new edge.
  always_comb begin
    sync_d  = {sync_q[LAST-1:0], dividedClock};
    valid_d = {valid_q[LAST-1:0], 1'b1};
    edge_d  = valid_q[LAST] ? sync_q[LAST] : 1'b1;
  end

  assign tick = sync_q[LAST] & ~edge_q;

  always_ff @(posedge sysClk or negedge sysRstN) begin
    if (!sysRstN) begin
      sync_q  <= '0;
      valid_q <= '0;
      edge_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      valid_q <= valid_d;
      edge_q  <= edge_d;
    end
  end

  // ---------------------------------------------------------------------------
  // BCD increment of the live count with minute wrap
  // ---------------------------------------------------------------------------
  count_t live_q, live_d;
  count_t disp_q, disp_d;
  count_t inc;
  logic   wrap;

  always_comb begin
    inc  = live_q;
    wrap = 1'b0;
    if (live_q.tenths != 4'd9) begin
      inc.tenths = live_q.tenths + 4'd1;
    end else begin
      inc.tenths = 4'd0;
      if (live_q.sec_ones != 4'd9) begin
        inc.sec_ones = live_q.sec_ones + 4'd1;
      end else begin
        inc.sec_ones = 4'd0;
        if (live_q.sec_tens != 4'd5) begin
          inc.sec_tens = live_q.sec_tens + 4'd1;
        end else begin
          inc.sec_tens = 4'd0;
          if (live_q.min_ones != 4'd9) begin
            inc.min_ones = live_q.min_ones + 4'd1;
          end else begin
            inc.min_ones = 4'd0;
            inc.min_tens = live_q.min_tens + 4'd1;
          end
          if ((inc.min_tens == WRAP_TENS) && (inc.min_ones == WRAP_ONES)) begin
            inc  = '0;
            wrap = 1'b1;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Control state machine, count, lap hold
  // ---------------------------------------------------------------------------
  state_e state_q, state_d;
  logic   lap_q, lap_d;
  logic   overflow_q, overflow_d;
  logic   clear_en;

  // startStopPulse has priority; clear is also ignored while running.
  assign clear_en = clearPulse && !startStopPulse && (state_q != ST_RUN);

  always_comb begin
    state_d    = state_q;
    live_d     = live_q;
    lap_d      = lap_q;
    overflow_d = 1'b0;

    // Counting is judged on the pre-transition state.
    if (tick && (state_q == ST_RUN)) begin
      live_d     = inc;
      overflow_d = wrap;
    end

    if (startStopPulse) begin
      case (state_q)
        ST_IDLE:  state_d = ST_RUN;
        ST_RUN:   state_d = ST_PAUSE;
        ST_PAUSE: state_d = ST_RUN;
        default:  state_d = ST_IDLE;
      endcase
    end

    if (lapPulse && (state_q != ST_IDLE)) begin
      lap_d = ~lap_q;
    end

    if (clear_en) begin
      state_d = ST_IDLE;
      live_d  = '0;
      lap_d   = 1'b0;
    end

    // Hold only while the lap stays active; on its rising transition the
    // pre-increment live count is captured, otherwise follow the live count.
    disp_d = (lap_q && lap_d) ? disp_q : live_q;
  end

  always_ff @(posedge sysClk or negedge sysRstN) begin
    if (!sysRstN) begin
      state_q    <= ST_IDLE;
      live_q     <= '0;
      disp_q     <= '0;
      lap_q      <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      live_q     <= live_d;
      disp_q     <= disp_d;
      lap_q      <= lap_d;
      overflow_q <= overflow_d;
    end
  end

  assign tenths        = disp_q.tenths;
  assign secOnes       = disp_q.sec_ones;
  assign secTens       = disp_q.sec_tens;
  assign minOnes       = disp_q.min_ones;
  assign minTens       = disp_q.min_tens;
  assign running       = (state_q == ST_RUN);
  assign lapActive     = lap_q;
  assign overflowPulse = overflow_q;

endmodule
